// File: rtl/spatz_decode_queue.sv
// Spatz decode queue: round-robin arbitration over NrPorts requesters, per-port
// decode, and a Depth-entry FIFO of decoded requests with config/CSR fencing.

// Per-port decoder: turns one raw instruction plus scalar operands into a
// compact request word.
module spatz_decode_queue_dec #(
  parameter int unsigned ElenW = 32
) (
  input  logic [31:0]      instr,
  input  logic [ElenW-1:0] rs1,
  input  logic [ElenW-1:0] rs2,
  output logic [1:0]       cls,
  output logic [4:0]       vd,
  output logic [4:0]       vs1,
  output logic [4:0]       vs2,
  output logic             vm,
  output logic             use_vs1,
  output logic [ElenW-1:0] operand,
  output logic [8:0]       vtype,
  output logic             illegal
);
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [11:0] csr;
  logic        rs2_unused;

  assign opcode     = instr[6:0];
  assign funct3     = instr[14:12];
  assign csr        = instr[31:20];
  // Only the low byte of rs2 carries a vtype (vsetvl).
  assign rs2_unused = ^rs2[ElenW-1:8];

  // Field extraction and class/operand selection by opcode.
  always_comb begin
    cls     = 2'd0;
    vd      = instr[11:7];
    vs1     = instr[19:15];
    vs2     = instr[24:20];
    vm      = instr[25];
    use_vs1 = 1'b0;
    operand = '0;
    vtype   = '0;
    illegal = 1'b0;
    case (opcode)
      7'h57: begin
        if (funct3 == 3'd7) begin
          cls = 2'd1;
          if (!instr[31]) begin
            vtype   = {1'b0, instr[27:20]};
            operand = rs1;
          end else if (instr[31:30] == 2'b11) begin
            vtype   = {1'b0, instr[27:20]};
            operand = ElenW'(instr[19:15]);
          end else if (instr[31:25] == 7'b1000000) begin
            vtype   = {1'b0, rs2[7:0]};
            operand = rs1;
          end else begin
            illegal = 1'b1;
          end
          // rs1=x0 with rd!=x0 requests VLMAX.
          if (instr[19:15] == 5'd0 && instr[11:7] != 5'd0) operand = '1;
        end else begin
          case (funct3)
            3'd0, 3'd2: use_vs1 = 1'b1;
            3'd3:       operand = ElenW'($signed(instr[19:15]));
            3'd4, 3'd6: operand = rs1;
            default:    illegal = 1'b1;
          endcase
        end
      end
      7'h73: begin
        cls     = 2'd2;
        operand = instr[14] ? ElenW'(instr[19:15]) : rs1;
        illegal = !((csr inside {12'h008, 12'h009, 12'h00A, 12'h00F,
                                 12'hC20, 12'hC21, 12'hC22}) &&
                    funct3 != 3'd0 && funct3 != 3'd4);
      end
      7'h07, 7'h27: begin
        cls     = 2'd3;
        operand = rs1;
        illegal = !(funct3 inside {3'd0, 3'd5, 3'd6, 3'd7});
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

module spatz_decode_queue #(
  parameter int unsigned NrPorts = 2,
  parameter int unsigned Depth   = 4,
  parameter int unsigned ElenW   = 32,
  parameter int unsigned IdW     = 5,
  localparam int unsigned PortW  = (NrPorts > 1) ? $clog2(NrPorts) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic [NrPorts-1:0]       req_valid_i,
  output logic [NrPorts-1:0]       req_ready_o,
  input  logic [NrPorts*32-1:0]    req_instr_i,
  input  logic [NrPorts*ElenW-1:0] req_rs1_i,
  input  logic [NrPorts*ElenW-1:0] req_rs2_i,
  input  logic [NrPorts*IdW-1:0]   req_id_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [1:0]               rsp_class_o,
  output logic [4:0]               rsp_vd_o,
  output logic [4:0]               rsp_vs1_o,
  output logic [4:0]               rsp_vs2_o,
  output logic                     rsp_vm_o,
  output logic                     rsp_use_vs1_o,
  output logic [ElenW-1:0]         rsp_operand_o,
  output logic [8:0]               rsp_vtype_o,
  output logic                     rsp_illegal_o,
  output logic [PortW-1:0]         rsp_port_o,
  output logic [IdW-1:0]           rsp_id_o,
  output logic                     busy_o,
  output logic [15:0]              illegal_cnt_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [1:0]       cls;
    logic [4:0]       vd;
    logic [4:0]       vs1;
    logic [4:0]       vs2;
    logic             vm;
    logic             use_vs1;
    logic [ElenW-1:0] operand;
    logic [8:0]       vtype;
    logic             illegal;
    logic [PortW-1:0] port;
    logic [IdW-1:0]   id;
  } entry_t;

  logic [NrPorts-1:0][1:0]       d_cls;
  logic [NrPorts-1:0][4:0]       d_vd, d_vs1, d_vs2;
  logic [NrPorts-1:0]            d_vm, d_use_vs1, d_illegal;
  logic [NrPorts-1:0][ElenW-1:0] d_operand;
  logic [NrPorts-1:0][8:0]       d_vtype;
  logic [NrPorts-1:0][IdW-1:0]   d_id;

  entry_t              mem [Depth];
  entry_t              head, wdata;
  logic [PtrW-1:0]     wptr, rptr;
  logic [CntW-1:0]     count;
  logic [PortW-1:0]    rr, gnt;
  logic                any_req, accept, pop, fence, head_fences;

  for (genvar p = 0; p < NrPorts; p++) begin : g_dec
    assign d_id[p] = req_id_i[p*IdW +: IdW];
    spatz_decode_queue_dec #(.ElenW(ElenW)) i_dec (
      .instr   (req_instr_i[p*32 +: 32]),
      .rs1     (req_rs1_i[p*ElenW +: ElenW]),
      .rs2     (req_rs2_i[p*ElenW +: ElenW]),
      .cls     (d_cls[p]),
      .vd      (d_vd[p]),
      .vs1     (d_vs1[p]),
      .vs2     (d_vs2[p]),
      .vm      (d_vm[p]),
      .use_vs1 (d_use_vs1[p]),
      .operand (d_operand[p]),
      .vtype   (d_vtype[p]),
      .illegal (d_illegal[p])
    );
  end

  // Round-robin search: first requesting port at or after rr, wrapping.
  always_comb begin
    logic [PortW-1:0] j;
    gnt     = '0;
    any_req = 1'b0;
    j       = rr;
    for (int i = 0; i < NrPorts; i++) begin
      if (!any_req && req_valid_i[j]) begin
        any_req = 1'b1;
        gnt     = j;
      end
      j = (j == PortW'(NrPorts - 1)) ? '0 : j + PortW'(1);
    end
  end

  assign head        = mem[rptr];
  assign accept      = any_req && (count < CntW'(Depth)) && !fence && !flush_i;
  assign pop         = rsp_valid_o && rsp_ready_i;
  // Only a legal VCFG/VCSR can be the fencing entry; at most one is queued.
  assign head_fences = !head.illegal && (head.cls == 2'd1 || head.cls == 2'd2);

  // One-hot accept toward the granted requester.
  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[gnt] = 1'b1;
  end

  // Assemble the decoded word of the granted port.
  always_comb begin
    wdata.cls     = d_cls[gnt];
    wdata.vd      = d_vd[gnt];
    wdata.vs1     = d_vs1[gnt];
    wdata.vs2     = d_vs2[gnt];
    wdata.vm      = d_vm[gnt];
    wdata.use_vs1 = d_use_vs1[gnt];
    wdata.operand = d_operand[gnt];
    wdata.vtype   = d_vtype[gnt];
    wdata.illegal = d_illegal[gnt];
    wdata.port    = gnt;
    wdata.id      = d_id[gnt];
  end

  // FIFO storage; contents are don't-care outside the valid window.
  always_ff @(posedge clk_i) begin
    if (accept) mem[wptr] <= wdata;
  end

  // Pointers, occupancy, fence, arbitration pointer and illegal statistics.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      fence         <= 1'b0;
      rr            <= '0;
      illegal_cnt_o <= '0;
    end else begin
      if (accept) begin
        rr <= (gnt == PortW'(NrPorts - 1)) ? '0 : gnt + PortW'(1);
        if (wdata.illegal && illegal_cnt_o != 16'hFFFF) illegal_cnt_o <= illegal_cnt_o + 16'd1;
      end
      if (flush_i) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
        fence <= 1'b0;
      end else begin
        if (accept) wptr <= wptr + PtrW'(1);
        if (pop)    rptr <= rptr + PtrW'(1);
        if (accept && !pop)      count <= count + CntW'(1);
        else if (!accept && pop) count <= count - CntW'(1);
        if (accept && !wdata.illegal && (wdata.cls == 2'd1 || wdata.cls == 2'd2)) fence <= 1'b1;
        else if (pop && head_fences) fence <= 1'b0;
      end
    end
  end

  assign rsp_valid_o   = (count != '0);
  assign busy_o        = (count != '0) || fence;
  assign rsp_class_o   = head.cls;
  assign rsp_vd_o      = head.vd;
  assign rsp_vs1_o     = head.vs1;
  assign rsp_vs2_o     = head.vs2;
  assign rsp_vm_o      = head.vm;
  assign rsp_use_vs1_o = head.use_vs1;
  assign rsp_operand_o = head.operand;
  assign rsp_vtype_o   = head.vtype;
  assign rsp_illegal_o = head.illegal;
  assign rsp_port_o    = head.port;
  assign rsp_id_o      = head.id;
endmodule

// File: tb/tb_spatz_decode_queue.sv
// Directed bench for spatz_decode_queue (NrPorts=2, Depth=4, ElenW=32, IdW=5).
module tb_spatz_decode_queue;
  logic        clk = 1'b0;
  logic        rst, flush, rsp_ready;
  logic [1:0]  req_valid, req_ready;
  logic [63:0] instr, rs1, rs2;
  logic [9:0]  ids;
  logic        rsp_valid, rsp_vm, rsp_use_vs1, rsp_illegal, busy;
  logic [1:0]  rsp_class;
  logic [4:0]  rsp_vd, rsp_vs1, rsp_vs2, rsp_id;
  logic [31:0] rsp_operand;
  logic [8:0]  rsp_vtype;
  logic [0:0]  rsp_port;
  logic [15:0] illegal_cnt;
  int n_vec = 0;
  int n_err = 0;

  spatz_decode_queue dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_instr_i(instr), .req_rs1_i(rs1), .req_rs2_i(rs2), .req_id_i(ids),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_class_o(rsp_class), .rsp_vd_o(rsp_vd), .rsp_vs1_o(rsp_vs1), .rsp_vs2_o(rsp_vs2),
    .rsp_vm_o(rsp_vm), .rsp_use_vs1_o(rsp_use_vs1), .rsp_operand_o(rsp_operand),
    .rsp_vtype_o(rsp_vtype), .rsp_illegal_o(rsp_illegal), .rsp_port_o(rsp_port),
    .rsp_id_o(rsp_id), .busy_o(busy), .illegal_cnt_o(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; rsp_ready = 1'b0; req_valid = '0;
    instr = '0; rs1 = '0; rs2 = '0; ids = '0;
    tick(); tick();
    rst = 1'b0; #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", illegal_cnt, 0);
    chk("rst_ready", req_ready, 0);

    // vadd.vv v1,v2,v3 from port 0
    rsp_ready = 1'b1; instr[31:0] = 32'h022180D7; ids[4:0] = 5'd3; req_valid = 2'b01; #1;
    chk("vv_ready", req_ready, 2'b01);
    tick(); req_valid = '0; #1;
    chk("vv_valid", rsp_valid, 1);
    chk("vv_class", rsp_class, 0);
    chk("vv_vd", rsp_vd, 1);
    chk("vv_vs1", rsp_vs1, 3);
    chk("vv_vs2", rsp_vs2, 2);
    chk("vv_use_vs1", rsp_use_vs1, 1);
    chk("vv_vm", rsp_vm, 1);
    chk("vv_operand", rsp_operand, 0);
    chk("vv_port", rsp_port, 0);
    chk("vv_id", rsp_id, 3);
    tick();
    chk("vv_popped", rsp_valid, 0);

    // vadd.vi v4,v8,-3 from port 1
    instr[63:32] = 32'h028EB257; ids[9:5] = 5'd7; req_valid = 2'b10; #1;
    chk("vi_ready", req_ready, 2'b10);
    tick(); req_valid = '0; #1;
    chk("vi_operand", rsp_operand, 32'hFFFFFFFD);
    chk("vi_use_vs1", rsp_use_vs1, 0);
    chk("vi_vd", rsp_vd, 4);
    chk("vi_vs2", rsp_vs2, 8);
    chk("vi_port", rsp_port, 1);
    chk("vi_id", rsp_id, 7);
    chk("vi_illegal", rsp_illegal, 0);
    tick();

    // vsetvli x5,x10,e32 fences the following request until popped
    rsp_ready = 1'b0; instr[31:0] = 32'h010572D7; rs1[31:0] = 32'd17; req_valid = 2'b01; #1;
    chk("cfg_ready", req_ready, 2'b01);
    tick(); instr[31:0] = 32'h022180D7; #1;
    chk("cfg_class", rsp_class, 1);
    chk("cfg_vtype", rsp_vtype, 9'h010);
    chk("cfg_operand", rsp_operand, 17);
    chk("cfg_vd", rsp_vd, 5);
    chk("cfg_busy", busy, 1);
    chk("cfg_hold0", req_ready, 0);
    tick();
    chk("cfg_hold1", req_ready, 0);
    chk("cfg_stable", rsp_class, 1);
    rsp_ready = 1'b1; #1;
    chk("cfg_hold_pop", req_ready, 0);
    tick();
    chk("cfg_resume", req_ready, 2'b01);
    tick(); req_valid = '0; #1;
    chk("cfg_next_valid", rsp_valid, 1);
    chk("cfg_next_class", rsp_class, 0);
    chk("cfg_next_vd", rsp_vd, 1);
    tick();
    chk("cfg_drained", busy, 0);

    // Both ports requesting: rr is at 1 here, so grants go 1,0,1,0
    ids[4:0] = 5'd10; ids[9:5] = 5'd21; req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("alt_ready", req_ready, (k % 2 == 0) ? 2'b10 : 2'b01);
      tick();
      chk("alt_port", rsp_port, (k % 2 == 0) ? 1 : 0);
      chk("alt_id", rsp_id, (k % 2 == 0) ? 21 : 10);
    end
    req_valid = '0;
    tick();
    chk("alt_empty", rsp_valid, 0);

    // Fill with 4 entries, stall the 5th, no pass-through when full
    rsp_ready = 1'b0; req_valid = 2'b10;
    for (int k = 0; k < 4; k++) begin
      ids[9:5] = 5'(k + 1); #1;
      chk("fill_ready", req_ready, 2'b10);
      tick();
    end
    ids[9:5] = 5'd5; #1;
    chk("full_stall", req_ready, 0);
    chk("full_head", rsp_id, 1);
    rsp_ready = 1'b1; #1;
    chk("full_nopass", req_ready, 0);
    tick();
    chk("full_resume", req_ready, 2'b10);
    rsp_ready = 1'b0;
    tick(); req_valid = '0; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("order_id", rsp_id, k + 2);
      tick();
    end
    chk("order_empty", rsp_valid, 0);

    // Two illegal opcodes, then flush
    rsp_ready = 1'b0; instr[31:0] = 32'h0000007F; req_valid = 2'b01; #1;
    chk("ill_ready0", req_ready, 2'b01);
    tick();
    chk("ill_ready1", req_ready, 2'b01);
    tick(); req_valid = '0; #1;
    chk("ill_flag", rsp_illegal, 1);
    chk("ill_class", rsp_class, 0);
    chk("ill_cnt", illegal_cnt, 2);
    chk("ill_busy", busy, 1);
    flush = 1'b1; req_valid = 2'b01; #1;
    chk("flush_block", req_ready, 0);
    tick(); flush = 1'b0; req_valid = '0; #1;
    chk("flush_valid", rsp_valid, 0);
    chk("flush_busy", busy, 0);
    chk("flush_cnt", illegal_cnt, 2);

    // csrrs x3, vl, x0 and an illegal-width load
    rsp_ready = 1'b1; instr[31:0] = 32'hC20021F3; rs1[31:0] = 32'hDEADBEEF; req_valid = 2'b01; #1;
    chk("csr_ready", req_ready, 2'b01);
    tick(); req_valid = '0; #1;
    chk("csr_class", rsp_class, 2);
    chk("csr_vd", rsp_vd, 3);
    chk("csr_operand", rsp_operand, 32'hDEADBEEF);
    chk("csr_illegal", rsp_illegal, 0);
    chk("csr_busy", busy, 1);
    tick();
    chk("csr_unfenced", busy, 0);
    instr[31:0] = 32'h00003007; req_valid = 2'b01; #1;
    chk("mem_ready", req_ready, 2'b01);
    tick(); req_valid = '0; #1;
    chk("mem_class", rsp_class, 3);
    chk("mem_illegal", rsp_illegal, 1);
    chk("mem_cnt", illegal_cnt, 3);
    tick();

    // Reset with 3 entries queued
    rsp_ready = 1'b0; instr[31:0] = 32'h022180D7; req_valid = 2'b11;
    tick(); tick(); tick();
    req_valid = '0; #1;
    chk("pre_rst_valid", rsp_valid, 1);
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("rst2_valid", rsp_valid, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_cnt", illegal_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
